instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000: PC value loaded on reset.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  asynchronous, active-low reset.
REQ-004 PCWre  input  1  PC write enable; 0 means halt, and no handshake transfer occurs.
REQ-005 PCSrc  input  2  next-PC select: 00 PC+4, 01 branch, 10 jump, 11 register (jr).
REQ-006 immediate  input  16  branch offset in words, signed.
REQ-007 addr  input  26  jump target field.
REQ-008 rs_data  input  32  register jump target.
REQ-009 imem_req  output  1  instruction-memory read request.
REQ-010 imem_addr  output  32  read address; always equals pc.
REQ-011 imem_ack  input  1  read data valid this cycle.
REQ-012 imem_rdata  input  32  instruction word.
REQ-013 ins  output  32  registered instruction presented to decode.
REQ-014 ins_valid  output  1  ins holds a fetched, unconsumed instruction.
REQ-015 ins_ready  input  1  decode accepts ins this cycle.
REQ-016 pc, pc4  output  32 each  address of ins, and that address plus 4.
REQ-017 addr_err  output  1  sticky misaligned-target flag; exists only under PC_ALIGN_CHECK_EN.

Function
REQ-018 The FSM SHALL have two states: FETCH (imem_req=1, ins_valid=0) and VALID (imem_req=0, ins_valid=1).
REQ-019 In FETCH, imem_ack=1 SHALL capture imem_rdata into ins and enter VALID on the next edge; imem_req SHALL hold until the ack.
REQ-020 imem_ack outside FETCH SHALL be ignored.
REQ-021 A transfer SHALL occur when state=VALID, ins_ready=1 and PCWre=1; pc SHALL load next_pc and the FSM SHALL return to FETCH.
REQ-022 The minimum fetch-to-fetch period SHALL be 2 cycles (ack cycle, then transfer cycle).
REQ-023 next_pc SHALL be computed combinationally from the inputs sampled in the transfer cycle:
  - 00: pc4.
  - 01: pc4 + (sign-extended immediate << 2).
  - 10: {pc4[31:28], addr, 2'b00}.
  - 11: rs_data.
REQ-024 All PC arithmetic SHALL wrap modulo 2^32; pc=32'hFFFFFFFC with PCSrc=00 SHALL yield 32'h00000000.
REQ-025 pc4 SHALL equal pc+4 combinationally at all times.
REQ-026 In VALID with PCWre=0, pc, ins, state and ins_valid SHALL hold regardless of ins_ready.
REQ-027 ins SHALL remain stable while ins_valid=1 until a transfer occurs.

Reset
REQ-028 Reset=0 SHALL immediately set pc=RESET_PC, ins=32'h0, state=FETCH, ins_valid=0 and addr_err=0 (under the macro); imem_req SHALL read 1 while in reset.
REQ-029 Reset asserted mid-fetch SHALL abandon the outstanding request; fetching SHALL restart at RESET_PC on the first edge after release.

Configuration
REQ-030 With PC_ALIGN_CHECK_EN defined:
  - A transfer with PCSrc=11 and rs_data[1:0]!=0 SHALL set addr_err.
  - pc SHALL NOT update, and the FSM SHALL stay in VALID.
  - addr_err SHALL clear only on reset.
  - While addr_err=1, further transfers SHALL be blocked.
REQ-031 Without PC_ALIGN_CHECK_EN, the addr_err port SHALL be absent and the PCSrc=11 target SHALL be {rs_data[31:2], 2'b00}.

Verification
REQ-032 Reset release, imem acks 1 cycle after req with rdata=32'h20080005, ins_ready=1, PCSrc=00 -> ins=32'h20080005, pc=0; next imem_addr=32'h4.
REQ-033 pc=32'h100, PCSrc=01, immediate=16'hFFFE at transfer -> next pc=32'hFC; immediate=16'h0003 -> 32'h110.
REQ-034 pc=32'h40000010, PCSrc=10, addr=26'h0000040 at transfer -> next pc=32'h40000100.
REQ-035 VALID with PCWre=0 and ins_ready=1 for 5 cycles -> pc, ins and ins_valid unchanged and imem_req=0; PCWre=1 -> transfer on that edge.
REQ-036 Reset pulsed while in FETCH with ack pending -> outputs at reset values immediately; the late ack after release fetches from RESET_PC.
REQ-037 Under PC_ALIGN_CHECK_EN, PCSrc=11 with rs_data=32'h00000102 -> addr_err=1 and pc held; without the macro -> next pc=32'h00000100.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch stage.
// Fetches one word from instruction memory, holds it for decode, and then
// computes the next PC when decode accepts the word.
// The FSM has two states. FETCH raises imem_req until the memory acks.
// VALID presents ins to decode until a transfer happens.
// Build option PC_ALIGN_CHECK_EN: when it is defined, a misaligned register
// jump raises a sticky addr_err and blocks further transfers. When it is not
// defined, the register jump target is forced to a word boundary.
// Handshake: a transfer happens on a rising edge where ins_valid=1,
// ins_ready=1 and PCWre=1. PCWre=0 freezes the stage whatever ins_ready is.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        PCWre,
    input  logic [1:0]  PCSrc,
    input  logic [15:0] immediate,
    input  logic [25:0] addr,
    input  logic [31:0] rs_data,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ins,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [31:0] pc,
    output logic [31:0] pc4,
`ifdef PC_ALIGN_CHECK_EN
    output logic        addr_err,
`endif
    output logic        dbg_state_o
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_VALID = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ins_q, ins_d;
    logic [31:0] pc4_w;
    logic [31:0] branch_off_w;
    logic [31:0] jr_tgt_w;
    logic [31:0] next_pc_w;
    logic        misalign_w;
    logic        blocked_w;
    logic        transfer_w;

`ifdef PC_ALIGN_CHECK_EN
    logic err_q, err_d;
    assign jr_tgt_w   = rs_data;
    assign misalign_w = (PCSrc == 2'b11) && (rs_data[1:0] != 2'b00);
    assign blocked_w  = err_q;
    assign addr_err   = err_q;
`else
    // Without the check, the low two bits of rs_data are dropped.
    assign jr_tgt_w   = rs_data & 32'hFFFF_FFFC;
    assign misalign_w = 1'b0;
    assign blocked_w  = 1'b0;
`endif

    assign pc4_w        = pc_q + 32'd4;
    assign branch_off_w = {{14{immediate[15]}}, immediate, 2'b00};
    assign transfer_w   = (state_q == S_VALID) && ins_ready && PCWre && !blocked_w;

    assign imem_req    = (state_q == S_FETCH);
    assign ins_valid   = (state_q == S_VALID);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign pc4         = pc4_w;
    assign ins         = ins_q;
    assign dbg_state_o = state_q;

    // Next-PC select from the inputs seen in the transfer cycle (wraps mod 2^32).
    always_comb begin
        next_pc_w = pc4_w;
        case (PCSrc)
            2'b00:   next_pc_w = pc4_w;
            2'b01:   next_pc_w = pc4_w + branch_off_w;
            2'b10:   next_pc_w = {pc4_w[31:28], addr, 2'b00};
            default: next_pc_w = jr_tgt_w;
        endcase
    end

    // FSM next-state: capture on ack in FETCH, advance PC on a transfer in VALID.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ins_d   = ins_q;
`ifdef PC_ALIGN_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            S_FETCH: begin
                if (imem_ack) begin
                    ins_d   = imem_rdata;
                    state_d = S_VALID;
                end
            end
            default: begin
                if (transfer_w) begin
                    if (misalign_w) begin
`ifdef PC_ALIGN_CHECK_EN
                        err_d = 1'b1;
`endif
                    end else begin
                        pc_d    = next_pc_w;
                        state_d = S_FETCH;
                    end
                end
            end
        endcase
    end

    // State registers; reset abandons any outstanding request.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ins_q   <= 32'h0;
`ifdef PC_ALIGN_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ins_q   <= ins_d;
`ifdef PC_ALIGN_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch. It uses a table of next-PC vectors, hand-written
// corner sequences and random traffic. Expected values come from a
// transaction-level model and from a queue of the instruction words fetched.
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        CLK;
    logic        Reset;
    logic        PCWre;
    logic [1:0]  PCSrc;
    logic [15:0] immediate;
    logic [25:0] addr;
    logic [31:0] rs_data;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] ins;
    logic        ins_valid;
    logic        ins_ready;
    logic [31:0] pc;
    logic [31:0] pc4;
`ifdef PC_ALIGN_CHECK_EN
    logic        addr_err;
`endif
    logic        dbg_state;

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    instr_fetch #(.RESET_PC(RST_PC)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .PCWre      (PCWre),
        .PCSrc      (PCSrc),
        .immediate  (immediate),
        .addr       (addr),
        .rs_data    (rs_data),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .ins        (ins),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .pc         (pc),
        .pc4        (pc4),
`ifdef PC_ALIGN_CHECK_EN
        .addr_err   (addr_err),
`endif
        .dbg_state_o(dbg_state)
    );

    // ---------------- model and scoreboard ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_pc;
    logic [31:0] m_ins;
    bit          m_have;
    bit          m_err;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] start_pc;
        logic [1:0]  src;
        logic [15:0] imm;
        logic [25:0] a;
        logic [31:0] rs;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_target(input logic [31:0] cur, input logic [1:0] src,
                                               input logic [15:0] imm, input logic [25:0] a,
                                               input logic [31:0] rs);
        logic [31:0] seq;
        int          off;
        seq = cur + 32'd4;
        off = int'($signed(imm)) * 4;
        case (src)
            2'd0:    return seq;
            2'd1:    return seq + 32'(off);
            2'd2:    return (seq & 32'hF000_0000) + (32'(a) * 4);
`ifdef PC_ALIGN_CHECK_EN
            default: return rs;
`else
            default: return rs - 32'(rs % 4);
`endif
        endcase
    endfunction

    task automatic model_reset();
        m_pc   = RST_PC;
        m_ins  = 32'h0;
        m_have = 1'b0;
        m_err  = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".imem_req"},  32'(imem_req),  32'(!m_have));
        chk({tag, ".ins_valid"}, 32'(ins_valid), 32'(m_have));
        chk({tag, ".pc"},        pc,             m_pc);
        chk({tag, ".imem_addr"}, imem_addr,      m_pc);
        chk({tag, ".pc4"},       pc4,            m_pc + 32'd4);
        chk({tag, ".ins"},       ins,            m_ins);
`ifdef PC_ALIGN_CHECK_EN
        chk({tag, ".addr_err"},  32'(addr_err),  32'(m_err));
`endif
    endtask

    // ---------------- driver tasks ----------------
    // Called at a negedge. It drives one cycle, advances the model at the
    // posedge, and checks the outputs at the next negedge.
    task automatic step(input string tag, input bit we, input logic [1:0] src,
                        input logic [15:0] imm, input logic [25:0] a, input logic [31:0] rs,
                        input bit ack, input logic [31:0] rd, input bit rdy);
        bit xfer;
        bit bad;
        PCWre      = we;
        PCSrc      = src;
        immediate  = imm;
        addr       = a;
        rs_data    = rs;
        imem_ack   = ack;
        imem_rdata = rd;
        ins_ready  = rdy;
        #1;
        xfer = m_have && we && rdy && !m_err;
`ifdef PC_ALIGN_CHECK_EN
        bad = (src == 2'd3) && (rs[1:0] != 2'b00);
`else
        bad = 1'b0;
`endif
        if (xfer && !bad) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s.sb_empty actual=consume expected=none", tag);
            end else begin
                chk({tag, ".sb_ins"}, ins, exp_q.pop_front());
            end
        end
        @(posedge CLK);
        if (!m_have) begin
            if (ack) begin
                m_ins  = rd;
                m_have = 1'b1;
                exp_q.push_back(rd);
            end
        end else if (xfer) begin
            if (bad) begin
                m_err = 1'b1;
            end else begin
                m_pc   = ref_target(m_pc, src, imm, a, rs);
                m_have = 1'b0;
            end
        end
        @(negedge CLK);
        check_all(tag);
    endtask

    task automatic fetch_word(input string tag, input logic [31:0] rd);
        step(tag, 1'b1, 2'd0, 16'h0, 26'h0, 32'h0, 1'b1, rd, 1'b0);
    endtask

    // Uses a register jump to land on target, then fetches the word there.
    task automatic goto_pc(input logic [31:0] target);
        if (!m_have) fetch_word("goto_f0", $urandom);
        step("goto_jr", 1'b1, 2'd3, 16'h0, 26'h0, target, 1'b0, 32'h0, 1'b1);
        fetch_word("goto_f1", $urandom);
    endtask

    // Called at a negedge. Asserts reset asynchronously between clock edges.
    task automatic pulse_reset(input string tag);
        #2 Reset = 1'b0;
        #1 model_reset();
        check_all({tag, ".async"});
        @(posedge CLK);
        @(negedge CLK);
        check_all({tag, ".held"});
        Reset = 1'b1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vecs[0] = '{32'h0000_0100, 2'd1, 16'hFFFE, 26'h0,      32'h0,          32'h0000_00FC};
        vecs[1] = '{32'h0000_0100, 2'd1, 16'h0003, 26'h0,      32'h0,          32'h0000_0110};
        vecs[2] = '{32'h4000_0010, 2'd2, 16'h0,    26'h0000040, 32'h0,         32'h4000_0100};
        vecs[3] = '{32'hFFFF_FFFC, 2'd0, 16'h0,    26'h0,      32'h0,          32'h0000_0000};
        vecs[4] = '{32'h0000_0200, 2'd3, 16'h0,    26'h0,      32'h1234_5678,  32'h1234_5678};
        vecs[5] = '{32'h7FFF_FFFC, 2'd1, 16'h7FFF, 26'h0,      32'h0,          32'h8001_FFFC};
        vecs[6] = '{32'h0000_0010, 2'd1, 16'h8000, 26'h0,      32'h0,          32'hFFFE_0014};
        vecs[7] = '{32'hF000_0000, 2'd2, 16'h0,    26'h3FFFFFF, 32'h0,         32'hFFFF_FFFC};

        Reset = 1'b0; PCWre = 1'b0; PCSrc = 2'd0; immediate = 16'h0; addr = 26'h0;
        rs_data = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0; ins_ready = 1'b0;
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        check_all("reset");
        Reset = 1'b1;

        // First fetch after reset: the memory acks one cycle after the request.
        step("boot_req", 1'b1, 2'd0, 16'h0, 26'h0, 32'h0, 1'b0, 32'h0, 1'b1);
        step("boot_ack", 1'b1, 2'd0, 16'h0, 26'h0, 32'h0, 1'b1, 32'h2008_0005, 1'b1);
        chk("boot.ins", ins, 32'h2008_0005);
        chk("boot.pc", pc, 32'h0);
        step("boot_xfer", 1'b1, 2'd0, 16'h0, 26'h0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("boot.next_addr", imem_addr, 32'h4);

        // Next-PC vectors.
        foreach (vecs[i]) begin
            goto_pc(vecs[i].start_pc);
            chk($sformatf("vec%0d.start", i), pc, vecs[i].start_pc);
            step($sformatf("vec%0d", i), 1'b1, vecs[i].src, vecs[i].imm, vecs[i].a,
                 vecs[i].rs, 1'b0, 32'h0, 1'b1);
            chk($sformatf("vec%0d.next_pc", i), pc, vecs[i].exp_pc);
        end

        // Hold: PCWre=0 freezes VALID even with ready high.
        fetch_word("hold_f", 32'hCAFE_0001);
        for (int i = 0; i < 5; i++)
            step("hold", 1'b0, 2'd1, 16'h0010, 26'h0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b1);
        chk("hold.ins", ins, 32'hCAFE_0001);
        chk("hold.req", 32'(imem_req), 32'h0);
        step("hold_go", 1'b1, 2'd0, 16'h0, 26'h0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("hold_go.valid", 32'(ins_valid), 32'h0);

        // Reset while an ack is still pending; the late ack fetches from RESET_PC.
        step("rst_wait", 1'b1, 2'd0, 16'h0, 26'h0, 32'h0, 1'b0, 32'h0, 1'b1);
        pulse_reset("midfetch");
        step("rst_ack", 1'b1, 2'd0, 16'h0, 26'h0, 32'h0, 1'b1, 32'h1111_2222, 1'b0);
        chk("rst_ack.pc", pc, RST_PC);
        chk("rst_ack.ins", ins, 32'h1111_2222);

        // Misaligned register jump.
        step("mis", 1'b1, 2'd3, 16'h0, 26'h0, 32'h0000_0102, 1'b0, 32'h0, 1'b1);
`ifdef PC_ALIGN_CHECK_EN
        chk("mis.addr_err", 32'(addr_err), 32'h1);
        chk("mis.pc", pc, RST_PC);
        step("mis_block", 1'b1, 2'd0, 16'h0, 26'h0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("mis_block.valid", 32'(ins_valid), 32'h1);
        pulse_reset("mis_clr");
`else
        chk("mis.pc", pc, 32'h0000_0100);
`endif

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] rs;
            rs = $urandom;
`ifdef PC_ALIGN_CHECK_EN
            if ($urandom_range(0, 31) != 0) rs = rs & 32'hFFFF_FFFC;
`endif
            step("rand", $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                 16'($urandom), 26'($urandom), rs, $urandom_range(0, 1) == 1,
                 $urandom, $urandom_range(0, 1) == 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
